// File: rtl/shift_seq_if.sv
// Request/response bundle between ALU issue logic and the shift sequencer.
// The master issues shift requests and consumes results; the slave is the sequencer.
interface shift_seq_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SHAMT_W = 4
);
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [SHAMT_W-1:0] req_shamt;
    logic [DATA_W-1:0]  req_data;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_data;
    logic               rsp_err;
    logic               busy;

    modport master (
        output req_valid, req_op, req_shamt, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_shamt, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle SLL/SRL/SRA sequencer: shifts at most STEP positions per cycle
// and holds the result on a valid/ready response port until consumed.
module shift_seq_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SHAMT_W = 4,
    parameter int unsigned STEP    = 1
) (
    input  logic       clk,
    input  logic       rst,
    shift_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [1:0]         OP_SLL   = 2'b00;
    localparam logic [1:0]         OP_SRL   = 2'b01;
    localparam logic [1:0]         OP_ILL   = 2'b11;
    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [SHAMT_W-1:0] k;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [DATA_W-1:0]  fill_mask;
    logic               sign_q, sign_d;
    logic               err_q, err_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q, busy_d;

    // Next-state, datapath step and registered-output decode
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rem_d     = rem_q;
        data_d    = data_q;
        sign_d    = sign_q;
        err_d     = err_q;
        k         = (rem_q > STEP_AMT) ? STEP_AMT : rem_q;
        fill_mask = ~({DATA_W{1'b1}} >> k);

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    op_d    = bus.req_op;
                    data_d  = bus.req_data;
                    sign_d  = bus.req_data[DATA_W-1];
                    err_d   = (bus.req_op == OP_ILL);
                    rem_d   = (bus.req_op == OP_ILL) ? '0 : bus.req_shamt;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    rem_d = rem_q - k;
                    // Arithmetic fill uses the sign captured at accept time
                    unique case (op_q)
                        OP_SLL:  data_d = data_q << k;
                        OP_SRL:  data_d = data_q >> k;
                        default: data_d = (data_q >> k) | (sign_q ? fill_mask : '0);
                    endcase
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rem_q       <= '0;
            data_q      <= '0;
            sign_q      <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rem_q       <= rem_d;
            data_q      <= data_d;
            sign_q      <= sign_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = busy_q;
endmodule
